fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of FIFO read data and stream data.
REQ-002 Parameter READ_LATENCY, default 1: cycles from fifo_read_enable to fifo_read_data_valid; legal values 1 or 2 (2 for pipelined memory).
REQ-003 Parameter BUFFER_DEPTH, default 4: output skid-buffer entries; legal range READ_LATENCY+1 to 16.
REQ-004 Port clock, input, 1: single clock for all logic.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port fifo_empty, input, 1: empty flag from the FIFO read side.
REQ-007 Port fifo_read_data, input, DATA_WIDTH: FIFO read data.
REQ-008 Port fifo_read_data_valid, input, 1: fifo_read_data qualifier.
REQ-009 Port fifo_read_enable, output, 1: read request to the FIFO.
REQ-010 Port flush, input, 1: discard buffered and in-flight words.
REQ-011 Port stream_ready, input, 1: downstream accepts the word.
REQ-012 Port stream_valid, output, 1: stream_data holds a word.
REQ-013 Port stream_data, output, DATA_WIDTH: head-of-buffer word.
REQ-014 Port buffer_level, output, $clog2(BUFFER_DEPTH+1): words held in the skid buffer.
REQ-015 Port overflow, output, 1: sticky error, a valid word arrived with the buffer full.

Function
REQ-016 Skid buffer SHALL be a circular buffer with write/read pointers wrapping at BUFFER_DEPTH; stream_valid = (buffer_level != 0); stream_data = entry at the read pointer.
REQ-017 Pop SHALL occur when stream_valid && stream_ready; read pointer advances by 1 with wrap; buffer_level decrements.
REQ-018 A word SHALL be written to the buffer on fifo_read_data_valid when neither flush nor a discard tag applies (REQ-024); write pointer advances with wrap; buffer_level increments.
REQ-019 Simultaneous push and pop SHALL leave buffer_level unchanged; no combinational bypass: a word pushed into an empty buffer reaches stream_valid the following cycle.
REQ-020 In-flight tracking SHALL be a READ_LATENCY-stage shift register recording each issued read; in_flight = count of set stages; stages retire after READ_LATENCY cycles irrespective of fifo_read_data_valid.
REQ-021 fifo_read_enable SHALL be asserted combinationally when fifo_empty == 0, flush == 0, reset == 0, and (buffer_level + in_flight - pop) < BUFFER_DEPTH.
REQ-022 Latency: read issued in cycle N -> fifo_read_data_valid in N+READ_LATENCY -> stream_valid in N+READ_LATENCY+1.
REQ-023 Throughput SHALL be one word per cycle sustained while fifo_empty == 0 and stream_ready == 1.
REQ-024 Flush SHALL, in the same cycle, clear both pointers and buffer_level to 0, suppress fifo_read_enable, and tag all in-flight stages for discard; tagged words arriving within the next READ_LATENCY cycles SHALL be dropped.
REQ-025 Flush concurrent with a pop or push SHALL take priority; resulting buffer_level = 0.
REQ-026 overflow SHALL set when an untagged fifo_read_data_valid arrives with buffer_level == BUFFER_DEPTH and no pop; the word is dropped; only reset clears it.
REQ-027 stream_data SHALL hold stable while stream_valid && !stream_ready.

Reset
REQ-028 While reset is high: pointers, buffer_level, in-flight stages, discard tags and overflow = 0; stream_valid = 0; fifo_read_enable = 0; stream_data = 0.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight words; first read SHALL issue no earlier than the cycle after reset deasserts.

Verification
REQ-030 READ_LATENCY=1, FIFO preloaded 0x0001..0x0008, stream_ready=1 -> stream_data 0x0001..0x0008 on consecutive cycles, first valid 2 cycles after first read, no gaps.
REQ-031 stream_ready=0, FIFO holds 10 words, BUFFER_DEPTH=4 -> exactly 4 reads issued, buffer_level=4, stream_data=first word held stable, overflow=0.
REQ-032 READ_LATENCY=2, stream_ready toggling 1/0 every cycle over 20 words -> all 20 words in order, none lost or duplicated, overflow=0.
REQ-033 Flush asserted one cycle after a read is issued with buffer_level=3 -> buffer_level=0 next cycle, in-flight word dropped, next streamed word is the following FIFO entry.
REQ-034 Reset asserted with buffer_level=2 and one read in flight -> after reset stream_valid=0, buffer_level=0; the in-flight word is not delivered.
REQ-035 Inject fifo_read_data_valid with no issued read while buffer_level=4, stream_ready=0 -> overflow=1 and stays 1 until reset.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Pulls words from a latency-1/2 FIFO read port into a circular skid buffer and
// presents them as a valid/ready stream; reads are credited against buffer space.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  fifo_empty,
  input  logic [DATA_WIDTH-1:0]                 fifo_read_data,
  input  logic                                  fifo_read_data_valid,
  output logic                                  fifo_read_enable,
  input  logic                                  flush,
  input  logic                                  stream_ready,
  output logic                                  stream_valid,
  output logic [DATA_WIDTH-1:0]                 stream_data,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     buffer_level,
  output logic                                  overflow
);

  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned LVL_W = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned IF_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned OCC_W = LVL_W + 2;

  logic [DATA_WIDTH-1:0]   mem_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [BUFFER_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [READ_LATENCY-1:0] stage_q, stage_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic                    overflow_q, overflow_d;

  logic [IF_W-1:0]         in_flight;
  logic                    pop;
  logic                    push;
  logic                    full;
  logic                    arr_tagged;
  logic                    read_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int unsigned k = 0; k < READ_LATENCY; k++) begin
      in_flight = in_flight + IF_W'(stage_q[k]);
    end
  end

  // The oldest stage is the read whose data is due this cycle, so its tag
  // decides whether the arriving word is kept.
  always_comb begin
    pop        = (level_q != '0) && stream_ready;
    full       = (level_q == LVL_W'(BUFFER_DEPTH));
    arr_tagged = stage_q[READ_LATENCY-1] & tag_q[READ_LATENCY-1];
    push       = fifo_read_data_valid && !flush && !arr_tagged && (!full || pop);
    read_en    = !fifo_empty && !flush && !reset &&
                 ((OCC_W'(level_q) + OCC_W'(in_flight)) < (OCC_W'(BUFFER_DEPTH) + OCC_W'(pop)));
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q |
                 (fifo_read_data_valid && !flush && !arr_tagged && full && !pop);

    if (push) begin
      mem_d[wr_ptr_q] = fifo_read_data;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Flush marks every outstanding read so its data is dropped on arrival.
    stage_d    = '0;
    tag_d      = '0;
    stage_d[0] = read_en;
    for (int unsigned k = 1; k < READ_LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
      tag_d[k]   = stage_q[k-1] & (tag_q[k-1] | flush);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      stage_q    <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      stage_q    <= stage_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    fifo_read_enable = read_en;
    stream_valid     = (level_q != '0);
    stream_data      = mem_q[rd_ptr_q];
    buffer_level     = level_q;
    overflow         = overflow_q;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: emulates the FIFO read port, models delivery with queues,
// and checks stream output order, buffer level, read issue and overflow.
module tb_fifo_stream_reader;

  localparam int unsigned W     = 16;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [W-1:0]  fifo_read_data;
  logic          fifo_read_data_valid;
  logic          fifo_read_enable;
  logic          flush;
  logic          stream_ready;
  logic          stream_valid;
  logic [W-1:0]  stream_data;
  logic [LW-1:0] buffer_level;
  logic          overflow;

  fifo_stream_reader #(
    .DATA_WIDTH  (W),
    .READ_LATENCY(RL),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .fifo_empty          (fifo_empty),
    .fifo_read_data      (fifo_read_data),
    .fifo_read_data_valid(fifo_read_data_valid),
    .fifo_read_enable    (fifo_read_enable),
    .flush               (flush),
    .stream_ready        (stream_ready),
    .stream_valid        (stream_valid),
    .stream_data         (stream_data),
    .buffer_level        (buffer_level),
    .overflow            (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           due;
    logic [W-1:0] data;
    bit           tag;
  } pend_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] src_q[$];
  pend_t        pending[$];

  bit ready_r, flush_r, reset_r, hold_empty, inject, ovf_m;
  int cyc;
  int n_checks, n_fail;
  int pop_cnt, first_pop_cyc, last_pop_cyc, rd_cnt, first_re_cyc;
  logic [W-1:0] first_pop_data;
  logic [W-1:0] next_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares the head word whenever the DUT presents one.
  always @(negedge clock) begin
    logic [W-1:0] hd;
    if (!reset && stream_valid) begin
      if (exp_q.size() == 0) begin
        chk("valid_with_empty_model", stream_valid, 0);
      end else begin
        chk("stream_data", stream_data, exp_q[0]);
        if (stream_ready) begin
          hd = exp_q.pop_front();
          if (pop_cnt == 0) begin
            first_pop_cyc  = cyc;
            first_pop_data = hd;
          end
          last_pop_cyc = cyc;
          pop_cnt++;
        end
      end
    end
  end

  // One clock cycle: drive inputs, check read issue, then update the model.
  task automatic step();
    bit arr_v, arr_t, from_pend, re, exp_re, pop_m;
    logic [W-1:0] arr_d;
    int unsigned sz, pend_cnt;
    pend_t p;
    arr_v = 0; arr_t = 0; from_pend = 0; arr_d = '0;
    if (pending.size() != 0 && pending[0].due == cyc) begin
      from_pend = 1; arr_v = 1; arr_d = pending[0].data; arr_t = pending[0].tag;
    end
    if (inject) begin
      arr_v = 1; arr_t = 0; arr_d = W'($urandom);
    end
    pend_cnt             = pending.size();
    fifo_empty           = hold_empty || (src_q.size() == 0);
    fifo_read_data_valid = arr_v;
    fifo_read_data       = arr_v ? arr_d : W'($urandom);
    stream_ready         = ready_r;
    flush                = flush_r;
    reset                = reset_r;
    #1;
    sz     = exp_q.size();
    pop_m  = (sz != 0) && ready_r;
    exp_re = !fifo_empty && !flush_r && !reset_r && ((sz + pend_cnt - pop_m) < DEPTH);
    chk("read_enable", fifo_read_enable, exp_re);
    re = fifo_read_enable;
    @(posedge clock);
    #1;
    if (from_pend) pending.delete(0);
    if (reset_r) begin
      exp_q.delete();
      ovf_m = 0;
    end else if (flush_r) begin
      exp_q.delete();
      foreach (pending[i]) pending[i].tag = 1;
    end else if (arr_v && !arr_t) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(arr_d);
      else ovf_m = 1;
    end
    if (re && src_q.size() != 0) begin
      p.due = cyc + RL; p.data = src_q.pop_front(); p.tag = 0;
      pending.push_back(p);
      rd_cnt++;
      if (first_re_cyc < 0) first_re_cyc = cyc;
    end
    cyc++;
    inject = 0;
    chk("buffer_level", buffer_level, exp_q.size());
    chk("stream_valid", stream_valid, exp_q.size() != 0);
    chk("overflow", overflow, ovf_m);
  endtask

  task automatic do_reset(input int n);
    reset_r = 1; flush_r = 0; inject = 0;
    repeat (n) step();
    reset_r = 0;
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) src_q.push_back(base + W'(i));
  endtask

  task automatic clear_track();
    pop_cnt = 0; rd_cnt = 0; first_re_cyc = -1; first_pop_cyc = 0; last_pop_cyc = 0;
  endtask

  task automatic drain();
    ready_r = 1; hold_empty = 0; flush_r = 0;
    for (int i = 0; i < 300 && (src_q.size() != 0 || exp_q.size() != 0 || pending.size() != 0); i++)
      step();
    chk("drain_level", buffer_level, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; ovf_m = 0; next_word = 16'h1000;
    ready_r = 0; flush_r = 0; reset_r = 1; hold_empty = 1; inject = 0;
    clear_track();

    // Preloaded stream with ready held high: back-to-back delivery.
    src_q.delete(); do_reset(RL + 1);
    chk("reset_level", buffer_level, 0);
    chk("reset_valid", stream_valid, 0);
    chk("reset_data", stream_data, 0);
    clear_track(); ready_r = 1; hold_empty = 0;
    load(8, 16'h0001);
    repeat (8 + RL + 4) step();
    chk("a_pop_count", pop_cnt, 8);
    chk("a_latency", first_pop_cyc - first_re_cyc, RL + 1);
    chk("a_no_gaps", last_pop_cyc - first_pop_cyc, 7);
    chk("a_first_data", first_pop_data, 16'h0001);

    // Stalled consumer: reads stop once credit is exhausted.
    src_q.delete(); do_reset(RL + 1);
    load(10, 16'h0100); clear_track(); ready_r = 0; hold_empty = 0;
    repeat (12) step();
    chk("b_reads_issued", rd_cnt, DEPTH);
    chk("b_level_full", buffer_level, DEPTH);
    chk("b_head_held", stream_data, 16'h0100);
    chk("b_no_overflow", overflow, 0);
    clear_track(); drain();
    chk("b_drain_count", pop_cnt, 10);

    // Flush one cycle after a read with three words buffered.
    src_q.delete(); do_reset(RL + 1);
    load(8, 16'h0200); clear_track(); ready_r = 0; hold_empty = 0;
    repeat (3) step();
    hold_empty = 1;
    repeat (RL + 1) step();
    chk("c_level3", buffer_level, 3);
    hold_empty = 0; step();
    chk("c_read_issued", rd_cnt, 4);
    flush_r = 1; step(); flush_r = 0;
    chk("c_flush_level", buffer_level, 0);
    clear_track(); drain();
    chk("c_next_word", first_pop_data, 16'h0204);
    chk("c_after_flush_count", pop_cnt, 4);

    // Reset with two buffered words and one read outstanding.
    src_q.delete(); do_reset(RL + 1);
    load(8, 16'h0300); clear_track(); ready_r = 0; hold_empty = 0;
    repeat (2) step();
    hold_empty = 1;
    repeat (RL + 1) step();
    chk("d_level2", buffer_level, 2);
    hold_empty = 0; step(); hold_empty = 1;
    do_reset(RL + 1);
    chk("d_valid_after_reset", stream_valid, 0);
    chk("d_level_after_reset", buffer_level, 0);
    repeat (RL + 2) step();
    chk("d_no_late_word", buffer_level, 0);
    clear_track(); drain();
    chk("d_next_word", first_pop_data, 16'h0303);

    // Unsolicited word into a full buffer raises a sticky overflow.
    src_q.delete(); do_reset(RL + 1);
    load(DEPTH, 16'h0400); ready_r = 0; hold_empty = 0;
    repeat (DEPTH + RL + 2) step();
    chk("e_level_full", buffer_level, DEPTH);
    hold_empty = 1; inject = 1; step();
    chk("e_overflow_set", overflow, 1);
    load(10, 16'h0500); hold_empty = 0;
    for (int i = 0; i < 20; i++) begin
      ready_r = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();
    chk("e_overflow_sticky", overflow, 1);
    do_reset(RL + 1);
    chk("e_overflow_cleared", overflow, 0);

    // Randomized traffic with back-pressure, empty gaps and flushes.
    src_q.delete(); do_reset(RL + 1);
    for (int i = 0; i < 1500; i++) begin
      ready_r    = ($urandom_range(0, 3) != 0);
      flush_r    = ($urandom_range(0, 31) == 0);
      hold_empty = ($urandom_range(0, 5) == 0);
      if (src_q.size() < 8 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(next_word);
        next_word = next_word + 1'b1;
      end
      step();
    end
    flush_r = 0;
    drain();
    chk("rand_no_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
